// File: rtl/alu_com.sv
// Shared alu operation encoding used by the alu and its initiators.
// Codes outside the named set are reserved and treated as illegal.
package alu_com;

  typedef logic [3:0] aluop;

  localparam aluop aluopADD = 4'd0;
  localparam aluop aluopSUB = 4'd1;
  localparam aluop aluopAND = 4'd2;
  localparam aluop aluopOR  = 4'd3;
  localparam aluop aluopXOR = 4'd4;
  localparam aluop aluopSHL = 4'd5;
  localparam aluop aluopSHR = 4'd6;

endpackage

// File: rtl/alu_cmd_issuer.sv
// Command FIFO in front of a combinational alu; one issue per cycle,
// result captured into a valid/ready response register.
module alu_cmd_issuer
  import alu_com::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [WIDTH-1:0] cmd_a_i,
  input  logic [WIDTH-1:0] cmd_b_i,
  input  aluop             cmd_op_i,
  input  logic [TAG_W-1:0] cmd_tag_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output aluop             alu_op_o,
  input  logic [WIDTH-1:0] alu_data_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_data_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             rsp_zero_o,
  output logic             rsp_err_o,
  output logic [15:0]      issued_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STALL
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] mem_a   [DEPTH];
  logic [WIDTH-1:0] mem_b   [DEPTH];
  aluop             mem_op  [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];

  logic [AW:0]      wp, rp;
  logic [AW-1:0]    wa, ra;
  logic             empty, full;
  logic             push, issue;
  logic             err;
  logic [WIDTH-1:0] res;

  assign wa    = wp[AW-1:0];
  assign ra    = rp[AW-1:0];
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wa == ra);

  assign cmd_ready_o = !full;

  assign push  = cmd_valid_i && !full && !flush_i;
  assign issue = !empty && (!rsp_valid_o || rsp_ready_i) && !flush_i;

  // Bus is parked at zero/ADD whenever nothing is issued.
  assign alu_a_o  = issue ? mem_a[ra]  : '0;
  assign alu_b_o  = issue ? mem_b[ra]  : '0;
  assign alu_op_o = issue ? mem_op[ra] : aluopADD;

  always_comb begin
    err = 1'b1;
    unique case (mem_op[ra])
      aluopADD, aluopSUB, aluopAND, aluopOR,
      aluopXOR, aluopSHL, aluopSHR: err = 1'b0;
      default: err = 1'b1;
    endcase
  end

  assign res = err ? '0 : alu_data_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp <= '0;
      rp <= '0;
    end else if (flush_i) begin
      rp <= wp;
    end else begin
      if (push)  wp <= wp + PTR_ONE;
      if (issue) rp <= rp + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_a[wa]   <= cmd_a_i;
      mem_b[wa]   <= cmd_b_i;
      mem_op[wa]  <= cmd_op_i;
      mem_tag[wa] <= cmd_tag_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_tag_o   <= '0;
      rsp_zero_o  <= 1'b0;
      rsp_err_o   <= 1'b0;
    end else if (flush_i) begin
      rsp_valid_o <= 1'b0;
    end else if (issue) begin
      rsp_valid_o <= 1'b1;
      rsp_data_o  <= res;
      rsp_tag_o   <= mem_tag[ra];
      rsp_zero_o  <= (res == '0);
      rsp_err_o   <= err;
    end else if (rsp_ready_i) begin
      rsp_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    issued_o <= '0;
    else if (issue) issued_o <= issued_o + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (push) state_d = RUN;
        RUN: begin
          if (rsp_valid_o && !rsp_ready_i && !empty)
            state_d = STALL;
          else if (empty && !push && (!rsp_valid_o || rsp_ready_i))
            state_d = IDLE;
        end
        STALL: if (rsp_ready_i) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Randomized and directed bench for alu_cmd_issuer against a
// queue-based transaction model.
module tb_alu_cmd_issuer;
  import alu_com::*;

  localparam int W = 32;
  localparam int D = 4;
  localparam int T = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [W-1:0] cmd_a = '0;
  logic [W-1:0] cmd_b = '0;
  aluop         cmd_op = aluopADD;
  logic [T-1:0] cmd_tag = '0;
  logic         flush = 1'b0;
  logic [W-1:0] alu_a, alu_b, alu_data;
  aluop         alu_op;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_data;
  logic [T-1:0] rsp_tag;
  logic         rsp_zero, rsp_err;
  logic [15:0]  issued;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.WIDTH(W), .DEPTH(D), .TAG_W(T)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
    .cmd_op_i(cmd_op), .cmd_tag_i(cmd_tag),
    .flush_i(flush),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
    .alu_data_i(alu_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_tag_o(rsp_tag),
    .rsp_zero_o(rsp_zero), .rsp_err_o(rsp_err),
    .issued_o(issued)
  );

  // Attached alu; reserved codes drive junk so the issuer must mask it.
  always_comb begin
    alu_data = 32'hDEAD_BEEF;
    case (alu_op)
      aluopADD: alu_data = alu_a + alu_b;
      aluopSUB: alu_data = alu_a - alu_b;
      aluopAND: alu_data = alu_a & alu_b;
      aluopOR:  alu_data = alu_a | alu_b;
      aluopXOR: alu_data = alu_a ^ alu_b;
      aluopSHL: alu_data = alu_a << alu_b[4:0];
      aluopSHR: alu_data = alu_a >> alu_b[4:0];
      default:  alu_data = 32'hDEAD_BEEF;
    endcase
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    aluop         op;
    logic [T-1:0] tag;
  } cmd_t;

  cmd_t         q[$];
  bit           m_held;
  logic [W-1:0] m_data;
  logic [T-1:0] m_tag;
  bit           m_zero, m_err;
  logic [15:0]  m_cnt;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_op(input cmd_t c, output logic [W-1:0] r,
                                 output bit e);
    longint unsigned a = c.a;
    longint unsigned b = c.b;
    int sh = int'(c.b % 32);
    e = 1'b0;
    r = '0;
    if (c.op == aluopADD)      r = W'((a + b) % (64'd1 << W));
    else if (c.op == aluopSUB) r = W'((a + (64'd1 << W) - b) % (64'd1 << W));
    else if (c.op == aluopAND) r = c.a & c.b;
    else if (c.op == aluopOR)  r = c.a | c.b;
    else if (c.op == aluopXOR) r = c.a ^ c.b;
    else if (c.op == aluopSHL) r = W'((a * (64'd1 << sh)) % (64'd1 << W));
    else if (c.op == aluopSHR) r = W'(a / (64'd1 << sh));
    else e = 1'b1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_held = 0;
    m_data = '0;
    m_tag  = '0;
    m_zero = 0;
    m_err  = 0;
    m_cnt  = '0;
  endtask

  task automatic check_outs();
    check("cmd_ready", cmd_ready, q.size() < D);
    check("rsp_valid", rsp_valid, m_held);
    check("rsp_data", rsp_data, m_data);
    check("rsp_tag", rsp_tag, m_tag);
    check("rsp_zero", rsp_zero, m_zero);
    check("rsp_err", rsp_err, m_err);
    check("issued", issued, m_cnt);
  endtask

  // Drive one cycle from just after a falling edge, then check at the next.
  task automatic step(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input aluop op, input logic [T-1:0] tg,
                      input bit fl, input bit rr);
    bit   iss, acc;
    cmd_t c;
    logic [W-1:0] r;
    bit   e;
    cmd_valid = v; cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tg;
    flush = fl; rsp_ready = rr;
    #1;
    iss = !fl && q.size() > 0 && (!m_held || rr);
    check("alu_a", alu_a, iss ? q[0].a : '0);
    check("alu_b", alu_b, iss ? q[0].b : '0);
    check("alu_op", alu_op, iss ? q[0].op : aluopADD);
    acc = v && q.size() < D && !fl;
    @(posedge clk);
    if (fl) begin
      q.delete();
      m_held = 0;
    end else begin
      if (iss) begin
        c = q.pop_front();
        ref_op(c, r, e);
        m_held = 1;
        m_data = r;
        m_tag  = c.tag;
        m_zero = (r == 0);
        m_err  = e;
        m_cnt++;
      end else if (rr) begin
        m_held = 0;
      end
      if (acc) q.push_back('{a: a, b: b, op: op, tag: tg});
    end
    @(negedge clk);
    check_outs();
  endtask

  task automatic idle(input bit rr);
    step(0, '0, '0, aluopADD, '0, 0, rr);
  endtask

  initial begin
    model_reset();
    #3;
    check_outs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_outs();

    // single ADD
    step(1, 5, 7, aluopADD, 3, 0, 1);
    check("add_early", rsp_valid, 1'b0);
    idle(1);
    check("add_valid", rsp_valid, 1'b1);
    check("add_data", rsp_data, 32'd12);
    check("add_tag", rsp_tag, 4'd3);

    // back-to-back
    step(1, 10, 10, aluopSUB, 1, 0, 1);
    step(1, 1, 4, aluopSHL, 2, 0, 1);
    check("b2b_sub", rsp_data, 32'd0);
    check("b2b_zero", rsp_zero, 1'b1);
    step(1, 32'hF0, 32'h0F, aluopXOR, 4, 0, 1);
    check("b2b_shl", rsp_data, 32'd16);
    idle(1);
    check("b2b_xor", rsp_data, 32'hFF);
    check("b2b_issued", issued, 16'd4);
    idle(1);
    idle(1);

    // backpressure: one held plus a full FIFO
    for (int i = 0; i < 5; i++)
      step(1, W'(10 * (i + 1)), W'(i), aluopADD, T'(i), 0, 0);
    check("bp_full", cmd_ready, 1'b0);
    idle(0);
    idle(0);
    check("bp_hold_data", rsp_data, 32'd10);
    check("bp_hold_tag", rsp_tag, 4'd0);
    idle(1);
    check("bp_next", rsp_data, 32'd21);
    for (int i = 0; i < 5; i++) idle(1);

    // reserved op code
    step(1, 3, 4, 4'd9, 5, 0, 1);
    idle(1);
    check("ill_err", rsp_err, 1'b1);
    check("ill_data", rsp_data, 32'd0);
    check("ill_zero", rsp_zero, 1'b1);
    idle(1);

    // flush with three queued and one held
    for (int i = 0; i < 4; i++)
      step(1, W'(i + 2), 1, aluopSUB, T'(i + 8), 0, 0);
    step(1, 9, 9, aluopADD, 15, 1, 0);
    check("fl_valid", rsp_valid, 1'b0);
    check("fl_ready", cmd_ready, 1'b1);
    for (int i = 0; i < 3; i++) idle(1);
    check("fl_quiet", rsp_valid, 1'b0);

    // async reset between edges
    step(1, 6, 6, aluopAND, 1, 0, 0);
    step(1, 7, 7, aluopOR, 2, 0, 0);
    #2;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    #1;
    model_reset();
    check_outs();
    check("rst_alu_a", alu_a, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_outs();
    step(1, 1, 1, aluopADD, 7, 0, 1);
    idle(1);
    check("rst_add", rsp_data, 32'd2);
    check("rst_tag", rsp_tag, 4'd7);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      step($urandom_range(0, 3) != 0, a, b, aluop'($urandom_range(0, 8)),
           T'($urandom), $urandom_range(0, 40) == 0,
           $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
